bit_serial_alu: RTL and testbench

- Sequential, bit-serial counterpart of the team's 6-bit ripple ALU.
- Accepts one operation per start request and processes one bit per clock, LSB first, through a single 1-bit datapath and a carry flip-flop.
- Uses the same ALUOp encoding and the same operand/result naming as the ripple ALU.
- Used where area matters more than latency; the ripple ALU stays the combinational reference for checking.

---
 rtl/bit_serial_alu.sv | 129 ++++++++++++
 tb/tb_bit_serial_alu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// Bit-serial AND/OR/ADD/SUB/SLT/NOR ALU: one bit per clk, LSB first; done pulses WIDTH cycles after accept.
// Backpressure: start is only taken while busy=0; requests during an op are dropped, not queued.
module bit_serial_alu #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  input  logic             CarryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [3:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_ai, w_bi, w_binv, w_sum, w_cout, w_bit;
  logic             w_sub, w_ovf, w_slt;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_final;
  logic             w_final_co, w_final_ovf;

  assign busy = (r_state == S_RUN);

  always_comb begin
    w_ai   = r_a_sh[0];
    w_bi   = r_b_sh[0];
    w_sub  = (r_op == OP_SUB) || (r_op == OP_SLT);
    w_binv = w_sub ? ~w_bi : w_bi;
    w_sum  = w_ai ^ w_binv ^ r_carry;
    w_cout = (w_ai & w_binv) | (w_ai & r_carry) | (w_binv & r_carry);
    case (r_op)
      OP_AND:                 w_bit = w_ai & w_bi;
      OP_OR:                  w_bit = w_ai | w_bi;
      OP_NOR:                 w_bit = ~(w_ai | w_bi);
      OP_ADD, OP_SUB, OP_SLT: w_bit = w_sum;
      default:                w_bit = 1'b0;
    endcase
    w_res = {w_bit, r_res_sh[WIDTH-1:1]};
    // Only meaningful on the MSB step: r_carry is then the carry into the sign bit.
    w_ovf = r_carry ^ w_cout;
    w_slt = w_sum ^ w_ovf;
    w_final     = w_res;
    w_final_co  = 1'b0;
    w_final_ovf = 1'b0;
    if (r_op == OP_SLT) begin
      w_final = {{(WIDTH-1){1'b0}}, w_slt};
    end else if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
      w_final_co  = w_cout;
      w_final_ovf = w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      done     <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_op     <= ALUOp;
            r_res_sh <= '0;
            r_cnt    <= '0;
            if (ALUOp == OP_ADD)
              r_carry <= CarryIn;
            else
              r_carry <= (ALUOp == OP_SUB) || (ALUOp == OP_SLT);
          end
        end
        default: begin
          r_res_sh <= w_res;
          r_carry  <= w_cout;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state  <= S_IDLE;
            done     <= 1'b1;
            Result   <= w_final;
            CarryOut <= w_final_co;
            Overflow <= w_final_ovf;
            Zero     <= (w_final == '0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu: directed ops push expectations, a negedge monitor pops on done.
module tb_bit_serial_alu;

  logic       clk = 1'b0;
  logic       reset, start, CarryIn;
  logic [5:0] a, b;
  logic [3:0] ALUOp;
  logic       busy, done, CarryOut, Overflow, Zero;
  logic [5:0] Result;

  typedef struct packed {
    logic [5:0] res;
    logic       co;
    logic       ovf;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  bit_serial_alu #(.WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUOp(ALUOp),
    .CarryIn(CarryIn), .busy(busy), .done(done), .Result(Result),
    .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",   int'(Result),   int'(e.res));
        chk("carryout", int'(CarryOut), int'(e.co));
        chk("overflow", int'(Overflow), int'(e.ovf));
        chk("zero",     int'(Zero),     int'(e.z));
      end
    end
  end

  // Drives one op from just after a posedge and returns just after its done edge,
  // so consecutive calls put start on the done cycle. hammer keeps start high and
  // scrambles the inputs for the whole op.
  task automatic issue(input logic [3:0] op, input logic [5:0] ta, input logic [5:0] tb_v,
                       input logic cin, input logic [5:0] er, input logic eco,
                       input logic eov, input bit hammer);
    int  lat;
    int  busy_n;
    bit  got;
    exp_t e;
    ALUOp = op; a = ta; b = tb_v; CarryIn = cin; start = 1'b1;
    e.res = er; e.co = eco; e.ovf = eov; e.z = (er == 6'd0);
    sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = int'(busy);
    lat    = 0;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (hammer) begin
        start = 1'b1; a = 6'd1; b = 6'd1; ALUOp = 4'b0110; CarryIn = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got   = 1'b1;
        start = 1'b0;
      end else begin
        busy_n += int'(busy);
      end
    end
    chk("latency", lat, 6);
    chk("busy_cycles", busy_n, 6);
    chk("busy_at_done", int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ALUOp = '0; CarryIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(Result), 0);
    chk("rst_carry", int'(CarryOut), 0);
    chk("rst_ovf", int'(Overflow), 0);
    chk("rst_zero", int'(Zero), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    //     op       a        b        cin   result          co    ovf  hammer
    issue(4'b0010, 6'd5,  6'd3,  1'b0, 6'd8,           1'b0, 1'b0, 1'b0);
    issue(4'b0010, 6'd5,  6'd3,  1'b1, 6'd9,           1'b0, 1'b0, 1'b0);
    issue(4'b0010, 6'd63, 6'd1,  1'b0, 6'd0,           1'b1, 1'b0, 1'b0);
    issue(4'b0010, 6'd31, 6'd1,  1'b0, 6'd32,          1'b0, 1'b1, 1'b0);
    issue(4'b0110, 6'd5,  6'd3,  1'b0, 6'd2,           1'b1, 1'b0, 1'b0);
    issue(4'b0110, 6'd5,  6'd3,  1'b1, 6'd2,           1'b1, 1'b0, 1'b0);
    issue(4'b0110, 6'd3,  6'd5,  1'b0, 6'd62,          1'b0, 1'b0, 1'b0);
    issue(4'b0110, 6'd32, 6'd1,  1'b0, 6'd31,          1'b1, 1'b1, 1'b0);
    issue(4'b0111, 6'd63, 6'd1,  1'b0, 6'd1,           1'b0, 1'b0, 1'b0);
    issue(4'b0111, 6'd1,  6'd63, 1'b0, 6'd0,           1'b0, 1'b0, 1'b0);
    issue(4'b0111, 6'd32, 6'd1,  1'b0, 6'd1,           1'b0, 1'b0, 1'b0);
    issue(4'b0000, 6'b101100, 6'b100110, 1'b1, 6'b100100, 1'b0, 1'b0, 1'b0);
    issue(4'b0001, 6'b101100, 6'b100110, 1'b0, 6'b101110, 1'b0, 1'b0, 1'b0);
    issue(4'b1100, 6'b101100, 6'b100110, 1'b0, 6'b010001, 1'b0, 1'b0, 1'b0);
    issue(4'b1111, 6'd63, 6'd63, 1'b1, 6'd0,           1'b0, 1'b0, 1'b0);
    issue(4'b0010, 6'd5,  6'd3,  1'b0, 6'd8,           1'b0, 1'b0, 1'b1);

    // Abort an ADD after three RUN edges; no expectation is queued for it.
    ALUOp = 4'b0010; a = 6'd20; b = 6'd20; CarryIn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_abort", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(Result), 0);
    chk("abort_carry", int'(CarryOut), 0);
    chk("abort_ovf", int'(Overflow), 0);
    chk("abort_zero", int'(Zero), 0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    issue(4'b0010, 6'd2, 6'd2, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
